// File: rtl/spin_pkg.sv
// -----------------------------------------------------------------------------
// spin_pkg
// Shared definitions for the spin-cycle sequencer: state encoding, RPM width
// and the constants used when the unbalance derate option is built in.
// Optional feature macro referenced by users of this package:
// SPIN_CYCLE_DERATE_EN.
// -----------------------------------------------------------------------------
package spin_pkg;

    localparam int unsigned RPM_W        = 11;
    localparam int unsigned DERATE_STEP  = 200;
    localparam int unsigned DERATE_FLOOR = 400;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_HOLD      = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_REDIST    = 3'd4,
        S_DONE      = 3'd5,
        S_FAULT     = 3'd6
    } spin_state_e;

    // Lower a target by one derate step without going below the floor;
    // targets already below the floor are left alone.
    function automatic logic [RPM_W-1:0] derate_target(input logic [RPM_W-1:0] t);
        logic [RPM_W-1:0] r;
        if (t < RPM_W'(DERATE_FLOOR)) begin
            r = t;
        end else if (t >= RPM_W'(DERATE_FLOOR + DERATE_STEP)) begin
            r = t - RPM_W'(DERATE_STEP);
        end else begin
            r = RPM_W'(DERATE_FLOOR);
        end
        return r;
    endfunction

endpackage

// File: rtl/spin_cycle_sequencer_if.sv
// -----------------------------------------------------------------------------
// spin_cycle_sequencer_if
// Signal bundle between the wash controller (master) and the spin-cycle
// sequencer (slave).
//   start, target_rpm, door_locked, unbalance, abort, fault_ack : to sequencer
//   motor_rpm, busy, done, fault, retry_count, state              : from sequencer
// -----------------------------------------------------------------------------
interface spin_cycle_sequencer_if;
    import spin_pkg::*;

    logic             start;
    logic [RPM_W-1:0] target_rpm;
    logic             door_locked;
    logic             unbalance;
    logic             abort;
    logic             fault_ack;

    logic [RPM_W-1:0] motor_rpm;
    logic             busy;
    logic             done;
    logic             fault;
    logic [1:0]       retry_count;
    logic [2:0]       state;

    modport master (
        output start, target_rpm, door_locked, unbalance, abort, fault_ack,
        input  motor_rpm, busy, done, fault, retry_count, state
    );

    modport slave (
        input  start, target_rpm, door_locked, unbalance, abort, fault_ack,
        output motor_rpm, busy, done, fault, retry_count, state
    );
endinterface

// File: rtl/spin_tick_gen.sv
// -----------------------------------------------------------------------------
// spin_tick_gen
// Free-running divider producing one tick every TICK_DIV clocks. A synchronous
// clear restarts the count so the first tick lands TICK_DIV cycles after it.
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   clr_i  : restart the count on the next edge
//   tick_o : high for one cycle when the count reaches TICK_DIV-1
// -----------------------------------------------------------------------------
module spin_tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);
    localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb tick_o = (cnt_q == LAST);

endmodule

// File: rtl/spin_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// spin_cycle_sequencer
// Runs the drum through one spin phase: ramp up to the latched target, hold
// for SPIN_TIME ticks, ramp down. Handles unbalance redistribution retries,
// door-open emergencies and user abort.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : slave side of spin_cycle_sequencer_if (commands in, motor
//           speed command and status out)
// Build option: SPIN_CYCLE_DERATE_EN lowers the target on each redistribution.
// -----------------------------------------------------------------------------
module spin_cycle_sequencer
    import spin_pkg::*;
#(
    parameter int unsigned RAMP_STEP     = 100,
    parameter int unsigned TICK_DIV      = 4,
    parameter int unsigned SPIN_TIME     = 20,
    parameter int unsigned MAX_RPM       = 1400,
    parameter int unsigned UNBAL_RETRIES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    spin_cycle_sequencer_if.slave bus
);
    localparam int unsigned      HOLD_W    = $clog2(SPIN_TIME + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SPIN_TIME - 1);
    localparam logic [RPM_W-1:0] MAX_C     = RPM_W'(MAX_RPM);
    localparam logic [RPM_W-1:0] STEP_C    = RPM_W'(RAMP_STEP);
    localparam logic [RPM_W:0]   STEP_W    = (RPM_W + 1)'(RAMP_STEP);
    localparam logic [1:0]       RETRY_MAX = 2'(UNBAL_RETRIES);

    spin_state_e       state_q, state_d;
    logic [RPM_W-1:0]  rpm_q, rpm_d;
    logic [RPM_W-1:0]  eff_q, eff_d;
    logic [1:0]        retry_q, retry_d;
    logic              abort_q, abort_d;
    logic              fpend_q, fpend_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic              tick;
    logic              state_entry;
    logic              active;
    logic [RPM_W-1:0]  target_clamped;
    logic [RPM_W-1:0]  redist_target;
    logic [RPM_W:0]    up_raw;
    logic [RPM_W-1:0]  up_sat;
    logic [RPM_W-1:0]  dn_sat;

    assign state_entry = (state_d != state_q);

    spin_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (state_entry),
        .tick_o (tick)
    );

    // Ramp datapath: one extra bit on the way up so the saturating compare
    // never sees a wrapped sum; on the way down the compare avoids underflow.
    always_comb begin
        target_clamped = (bus.target_rpm > MAX_C) ? MAX_C : bus.target_rpm;
        up_raw         = {1'b0, rpm_q} + STEP_W;
        up_sat         = (up_raw >= {1'b0, eff_q}) ? eff_q : up_raw[RPM_W-1:0];
        dn_sat         = (rpm_q > STEP_C) ? (rpm_q - STEP_C) : '0;
`ifdef SPIN_CYCLE_DERATE_EN
        redist_target  = derate_target(eff_q);
`else
        redist_target  = eff_q;
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rpm_q   <= '0;
            eff_q   <= '0;
            retry_q <= '0;
            abort_q <= 1'b0;
            fpend_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            rpm_q   <= rpm_d;
            eff_q   <= eff_d;
            retry_q <= retry_d;
            abort_q <= abort_d;
            fpend_q <= fpend_d;
            hold_q  <= hold_d;
        end
    end

    // Next state; priority is door emergency, abort, unbalance, tick.
    always_comb begin
        state_d = state_q;
        rpm_d   = rpm_q;
        eff_d   = eff_q;
        retry_d = retry_q;
        abort_d = abort_q;
        fpend_d = fpend_q;
        hold_d  = (state_q == S_HOLD) ? hold_q : '0;

        if (active && !bus.door_locked) begin
            state_d = S_FAULT;
            rpm_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && bus.door_locked) begin
                        eff_d   = target_clamped;
                        retry_d = '0;
                        abort_d = 1'b0;
                        fpend_d = 1'b0;
                        state_d = (target_clamped == '0) ? S_DONE : S_RAMP_UP;
                    end
                end
                S_RAMP_UP, S_HOLD: begin
                    if (bus.abort) begin
                        state_d = S_RAMP_DOWN;
                        abort_d = 1'b1;
                    end else if (bus.unbalance) begin
                        if (retry_q < RETRY_MAX) begin
                            state_d = S_REDIST;
                            retry_d = retry_q + 2'd1;
                            eff_d   = redist_target;
                        end else begin
                            // Out of retries: spin down first, fault at standstill.
                            state_d = S_RAMP_DOWN;
                            fpend_d = 1'b1;
                        end
                    end else if (tick) begin
                        if (state_q == S_RAMP_UP) begin
                            rpm_d = up_sat;
                            if (up_sat == eff_q) begin
                                state_d = S_HOLD;
                            end
                        end else if (hold_q == HOLD_LAST) begin
                            state_d = S_RAMP_DOWN;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                S_REDIST: begin
                    if (bus.abort) begin
                        state_d = S_RAMP_DOWN;
                        abort_d = 1'b1;
                    end else if (tick) begin
                        rpm_d = dn_sat;
                        if (dn_sat == '0) begin
                            state_d = S_RAMP_UP;
                        end
                    end
                end
                S_RAMP_DOWN: begin
                    if (bus.abort) begin
                        abort_d = 1'b1;
                    end
                    if (tick) begin
                        rpm_d = dn_sat;
                        if (dn_sat == '0) begin
                            if (fpend_q) begin
                                state_d = S_FAULT;
                            end else if (abort_q || bus.abort) begin
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                S_FAULT: begin
                    if (bus.fault_ack) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        active          = (state_q == S_RAMP_UP)   || (state_q == S_HOLD) ||
                          (state_q == S_RAMP_DOWN) || (state_q == S_REDIST) ||
                          (state_q == S_DONE);
        bus.busy        = active;
        bus.done        = (state_q == S_DONE);
        bus.fault       = (state_q == S_FAULT);
        bus.motor_rpm   = rpm_q;
        bus.retry_count = retry_q;
        bus.state       = state_q;
    end

endmodule

// File: tb/tb_spin_cycle_sequencer.sv
module tb_spin_cycle_sequencer;
    localparam int RAMP_STEP     = 100;
    localparam int TICK_DIV      = 4;
    localparam int SPIN_TIME     = 20;
    localparam int MAX_RPM       = 1400;
    localparam int UNBAL_RETRIES = 3;

    localparam int P_IDLE   = 0;
    localparam int P_UP     = 1;
    localparam int P_HOLD   = 2;
    localparam int P_DOWN   = 3;
    localparam int P_REDIST = 4;
    localparam int P_DONE   = 5;
    localparam int P_FAULT  = 6;

`ifdef SPIN_CYCLE_DERATE_EN
    localparam int RE1 = 600;
`else
    localparam int RE1 = 800;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   done_seen = 0;

    spin_cycle_sequencer_if bus();

    spin_cycle_sequencer #(
        .RAMP_STEP     (RAMP_STEP),
        .TICK_DIV      (TICK_DIV),
        .SPIN_TIME     (SPIN_TIME),
        .MAX_RPM       (MAX_RPM),
        .UNBAL_RETRIES (UNBAL_RETRIES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int ph;
        int rpm;
        int tgt;
        int retry;
        int cyc;    // cycles spent in the current phase
        bit ab;
        bit fp;
    } m_t;

    m_t m;

    function automatic m_t m_rst();
        m_t r;
        r.ph = P_IDLE; r.rpm = 0; r.tgt = 0; r.retry = 0; r.cyc = 0; r.ab = 0; r.fp = 0;
        return r;
    endfunction

    function automatic int derated(input int t);
`ifdef SPIN_CYCLE_DERATE_EN
        if (t < 400) return t;
        return (t - 200 < 400) ? 400 : t - 200;
`else
        return t;
`endif
    endfunction

    function automatic m_t mstep(input m_t s, input bit st, input int tr, input bit dl,
                                 input bit ub, input bit ab, input bit ack);
        m_t n;
        bit tk;
        int up, dn;
        n  = s;
        tk = (s.cyc % TICK_DIV) == TICK_DIV - 1;
        up = (s.rpm + RAMP_STEP > s.tgt) ? s.tgt : s.rpm + RAMP_STEP;
        dn = (s.rpm > RAMP_STEP) ? s.rpm - RAMP_STEP : 0;
        if (s.ph >= P_UP && s.ph <= P_DONE && !dl) begin
            n.ph = P_FAULT; n.rpm = 0;
        end else if (s.ph == P_IDLE) begin
            if (st && dl) begin
                n.tgt = (tr > MAX_RPM) ? MAX_RPM : tr;
                n.retry = 0; n.ab = 0; n.fp = 0;
                n.ph = (n.tgt == 0) ? P_DONE : P_UP;
            end
        end else if (s.ph == P_UP || s.ph == P_HOLD) begin
            if (ab) begin
                n.ph = P_DOWN; n.ab = 1;
            end else if (ub) begin
                if (s.retry < UNBAL_RETRIES) begin
                    n.ph = P_REDIST; n.retry = s.retry + 1; n.tgt = derated(s.tgt);
                end else begin
                    n.ph = P_DOWN; n.fp = 1;
                end
            end else if (s.ph == P_UP && tk) begin
                n.rpm = up;
                if (up == s.tgt) n.ph = P_HOLD;
            end else if (s.ph == P_HOLD && s.cyc == SPIN_TIME * TICK_DIV - 1) begin
                n.ph = P_DOWN;
            end
        end else if (s.ph == P_REDIST) begin
            if (ab) begin
                n.ph = P_DOWN; n.ab = 1;
            end else if (tk) begin
                n.rpm = dn;
                if (dn == 0) n.ph = P_UP;
            end
        end else if (s.ph == P_DOWN) begin
            if (ab) n.ab = 1;
            if (tk) begin
                n.rpm = dn;
                if (dn == 0) n.ph = s.fp ? P_FAULT : ((s.ab || ab) ? P_IDLE : P_DONE);
            end
        end else if (s.ph == P_DONE) begin
            n.ph = P_IDLE;
        end else if (s.ph == P_FAULT) begin
            if (ack) n.ph = P_IDLE;
        end
        n.cyc = (n.ph != s.ph) ? 0 : s.cyc + 1;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= m_rst();
        else m <= mstep(m, bus.start, int'(bus.target_rpm), bus.door_locked,
                        bus.unbalance, bus.abort, bus.fault_ack);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (int'(bus.motor_rpm) != m.rpm || int'(bus.state) != m.ph ||
                int'(bus.retry_count) != m.retry ||
                bus.busy != (m.ph >= P_UP && m.ph <= P_DONE) ||
                bus.done != (m.ph == P_DONE) || bus.fault != (m.ph == P_FAULT)) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t got st=%0d rpm=%0d retry=%0d busy=%0b done=%0b fault=%0b exp st=%0d rpm=%0d retry=%0d",
                         $time, bus.state, bus.motor_rpm, bus.retry_count, bus.busy, bus.done,
                         bus.fault, m.ph, m.rpm, m.retry);
            end
            if (bus.done) done_seen++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_st(input int s, input int budget, input string nm);
        int k = 0;
        while (int'(bus.state) != s && k < budget) begin
            cyc(1);
            k++;
        end
        chk(nm, int'(bus.state), s);
    endtask

    task automatic begin_spin(input int tgt);
        bus.target_rpm = 11'(tgt);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        bus.target_rpm = 11'd5;   // later changes must not matter
    endtask

    task automatic pulse_unb();
        bus.unbalance = 1'b1;
        cyc(1);
        bus.unbalance = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.target_rpm = '0; bus.door_locked = 1;
        bus.unbalance = 0; bus.abort = 0; bus.fault_ack = 0;
        #12;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_rpm", int'(bus.motor_rpm), 0);
        chk("rst_flags", {bus.busy, bus.done, bus.fault}, 0);
        chk("rst_retry", int'(bus.retry_count), 0);
        cyc(2);
        reset = 1'b0;
        cyc(1);

        // start without door lock is dropped
        bus.door_locked = 0; bus.start = 1;
        cyc(3);
        chk("no_door_start", int'(bus.state), P_IDLE);
        bus.start = 0; bus.door_locked = 1;
        cyc(1);

        // normal 800 cycle
        begin_spin(800);
        chk("t1_accept", int'(bus.state), P_UP);
        cyc(3);  chk("t1_rpm_e3", int'(bus.motor_rpm), 0);
        cyc(1);  chk("t1_rpm_e4", int'(bus.motor_rpm), 100);
        cyc(27); chk("t1_rpm_e31", int'(bus.motor_rpm), 700);
        cyc(1);  chk("t1_rpm_e32", int'(bus.motor_rpm), 800);
        chk("t1_hold", int'(bus.state), P_HOLD);
        chk("model_pin_800", m.rpm, 800);
        cyc(80); chk("t1_down_entry", int'(bus.state), P_DOWN);
        cyc(32); chk("t1_done", int'(bus.done), 1);
        chk("t1_done_rpm", int'(bus.motor_rpm), 0);
        cyc(1);  chk("t1_idle", int'(bus.state), P_IDLE);
        chk("t1_done_count", done_seen, 1);

        // clamp at MAX_RPM, then abort from HOLD
        begin_spin(2000);
        cyc(56); chk("t2_clamp_rpm", int'(bus.motor_rpm), 1400);
        chk("t2_hold", int'(bus.state), P_HOLD);
        chk("model_pin_tgt", m.tgt, 1400);
        bus.abort = 1; cyc(1); bus.abort = 0;
        chk("t2_abort_down", int'(bus.state), P_DOWN);
        wait_st(P_IDLE, 100, "t2_idle");
        chk("t2_no_done", done_seen, 1);

        // partial last step on the way up and down
        begin_spin(1150);
        cyc(44); chk("t3_1100", int'(bus.motor_rpm), 1100);
        cyc(4);  chk("t3_1150", int'(bus.motor_rpm), 1150);
        chk("t3_hold", int'(bus.state), P_HOLD);
        cyc(84); chk("t3_1050", int'(bus.motor_rpm), 1050);
        cyc(40); chk("t3_50", int'(bus.motor_rpm), 50);
        cyc(4);  chk("t3_zero", int'(bus.motor_rpm), 0);
        chk("t3_done", int'(bus.state), P_DONE);
        cyc(1);  chk("t3_done_count", done_seen, 2);

        // unbalance retries then exhaustion
        begin_spin(800);
        cyc(24); chk("t4_600", int'(bus.motor_rpm), 600);
        pulse_unb();
        chk("t4_redist", int'(bus.state), P_REDIST);
        chk("t4_retry1", int'(bus.retry_count), 1);
        wait_st(P_UP, 40, "t4_reramp");
        chk("t4_reramp_rpm", int'(bus.motor_rpm), 0);
        wait_st(P_HOLD, 60, "t4_hold1");
        chk("t4_hold1_rpm", int'(bus.motor_rpm), RE1);
        pulse_unb(); chk("t4_retry2", int'(bus.retry_count), 2);
        wait_st(P_HOLD, 200, "t4_hold2");
        pulse_unb(); chk("t4_retry3", int'(bus.retry_count), 3);
        wait_st(P_HOLD, 200, "t4_hold3");
        pulse_unb();
        chk("t4_exhaust", int'(bus.state), P_DOWN);
        chk("t4_exhaust_retry", int'(bus.retry_count), 3);
        wait_st(P_FAULT, 200, "t4_fault");
        chk("t4_fault_flags", {bus.fault, bus.busy}, 2);
        bus.start = 1; cyc(3);
        chk("t4_start_ignored", int'(bus.state), P_FAULT);
        bus.start = 0; bus.fault_ack = 1; cyc(1); bus.fault_ack = 0;
        chk("t4_ack_idle", int'(bus.state), P_IDLE);

        // door opens during HOLD
        begin_spin(500);
        wait_st(P_HOLD, 40, "t5_hold");
        chk("t5_hold_rpm", int'(bus.motor_rpm), 500);
        cyc(3);
        bus.door_locked = 0; cyc(1);
        chk("t5_door_rpm", int'(bus.motor_rpm), 0);
        chk("t5_door_flags", {bus.fault, bus.busy}, 2);
        bus.door_locked = 1; bus.start = 1; cyc(3);
        chk("t5_start_ignored", int'(bus.state), P_FAULT);
        bus.start = 0; bus.fault_ack = 1; cyc(1); bus.fault_ack = 0;
        chk("t5_ack_idle", int'(bus.state), P_IDLE);

        // abort during ramp up
        begin_spin(800);
        cyc(12); chk("t6_300", int'(bus.motor_rpm), 300);
        bus.abort = 1; cyc(1); bus.abort = 0;
        chk("t6_down", int'(bus.state), P_DOWN);
        cyc(4);  chk("t6_200", int'(bus.motor_rpm), 200);
        cyc(4);  chk("t6_100", int'(bus.motor_rpm), 100);
        cyc(4);  chk("t6_idle", int'(bus.state), P_IDLE);
        chk("t6_no_done", done_seen, 2);

        // abort beats unbalance
        begin_spin(800);
        cyc(16);
        bus.abort = 1; bus.unbalance = 1; cyc(1); bus.abort = 0; bus.unbalance = 0;
        chk("t7_down", int'(bus.state), P_DOWN);
        chk("t7_retry", int'(bus.retry_count), 0);
        wait_st(P_IDLE, 40, "t7_idle");

        // zero target goes straight to DONE
        begin_spin(0);
        chk("t8_done", int'(bus.state), P_DONE);
        cyc(1);
        chk("t8_idle", int'(bus.state), P_IDLE);
        chk("t8_done_count", done_seen, 3);

        // asynchronous reset mid-HOLD
        begin_spin(800);
        wait_st(P_HOLD, 40, "t9_hold");
        cyc(5);
        #1 reset = 1'b1;
        #1;
        chk("t9_async_state", int'(bus.state), 0);
        chk("t9_async_rpm", int'(bus.motor_rpm), 0);
        chk("t9_async_flags", {bus.busy, bus.done, bus.fault}, 0);
        cyc(2);
        reset = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spin_cycle_sequencer.md
Name: spin_cycle_sequencer

Overview:
- Sequences the drum motor through one spin phase: ramp up to the selected spin speed, hold, then ramp down.
- Takes the speed chosen by the spin-speed selector logic as target_rpm.
- Drives the motor speed command and handles drum unbalance retries, door-unlock emergencies and user abort.
- Sits between the spin-speed selection and the motor driver, under the top-level wash FSM.

Parameters:
- RAMP_STEP, 100, rpm added or removed per ramp tick.
- TICK_DIV, 4, clk cycles per ramp/hold tick (>=2).
- SPIN_TIME, 20, ticks spent holding at target.
- MAX_RPM, 1400, clamp applied to target_rpm.
- UNBAL_RETRIES, 3, unbalance recoveries allowed before fault.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; begin spin when sampled high in IDLE.
- target_rpm  in  11  requested spin speed, latched at start.
- door_locked  in  1  door interlock status.
- unbalance  in  1  drum unbalance detector.
- abort  in  1  user cancel.
- fault_ack  in  1  clears FAULT.
- motor_rpm  out  11  speed command to motor driver.
- busy  out  1  high in any state except IDLE and FAULT.
- done  out  1  one-cycle pulse on normal completion.
- fault  out  1  high in FAULT.
- retry_count  out  2  unbalance recoveries used in the current cycle.
- state  out  3  current state encoding, for debug.

Behaviour:
- Reset values: state=IDLE, motor_rpm=0, busy=0, done=0, fault=0, retry_count=0, tick counter=0.
- Clamp: eff_target = min(target_rpm, MAX_RPM), latched on the start-accept edge.
- Tick: counter runs 0..TICK_DIV-1 and is cleared on every state entry. A tick pulse occurs when the counter reaches TICK_DIV-1, so the first tick falls TICK_DIV cycles after entry.
- Ramp arithmetic: all ramp math uses 12 bits internally and saturates at eff_target on the way up and at 0 on the way down. No wrap is permitted.
- IDLE:
  - start && door_locked -> RAMP_UP; latch eff_target; retry_count=0.
  - start && !door_locked -> stay in IDLE; the request is ignored, not queued.
  - If eff_target==0 -> go straight to DONE next cycle.
- RAMP_UP: each tick, motor_rpm += RAMP_STEP, saturating. When motor_rpm==eff_target -> HOLD.
- HOLD: after SPIN_TIME ticks -> RAMP_DOWN.
- RAMP_DOWN: each tick, motor_rpm -= RAMP_STEP, saturating at 0. When 0 -> DONE, or -> IDLE if entered via abort.
- REDIST:
  - Entered on unbalance in RAMP_UP or HOLD while retry_count < UNBAL_RETRIES; retry_count increments on entry.
  - Ramps down like RAMP_DOWN; at 0 -> RAMP_UP toward the same eff_target.
- Retry exhaustion: unbalance while retry_count==UNBAL_RETRIES -> RAMP_DOWN with a fault flag set; when motor_rpm reaches 0 -> FAULT.
- DONE: done=1 for exactly one cycle -> IDLE.
- FAULT: motor_rpm=0, fault=1. fault_ack -> IDLE. start is ignored until acknowledged.
- Door emergency: door_locked low in any busy state forces motor_rpm=0 on the next edge and -> FAULT. This has the highest priority.
- Event priority, highest first: door emergency, abort, unbalance, normal tick progression.
  - Abort in RAMP_UP/HOLD/REDIST -> RAMP_DOWN, no done pulse.
  - Abort in RAMP_DOWN keeps ramping down, with done suppressed.
- unbalance is ignored in RAMP_DOWN, REDIST, DONE and IDLE.
- target_rpm changes after start has no effect until the next start.

Optional Feature:
- Macro: SPIN_CYCLE_DERATE_EN.
- Defined: each REDIST entry reduces eff_target by 200 rpm, floored at 400; if eff_target is already below 400 it is unchanged. The following RAMP_UP targets the derated value.
- Undefined: eff_target is constant for the whole cycle.

Decomposition:
- Shared package spin_pkg: state encoding constants (IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3, REDIST=4, DONE=5, FAULT=6), RPM width 11, derate step 200 and floor 400.
- One sub-module, spin_tick_gen: a tick divider with a synchronous clear on state entry.
- The ramp datapath stays inline.

Test Plan (defaults):
- Normal cycle: target 800, door locked, start -> motor_rpm 100,200,..,800 every 4 cycles, reaching 800 at 32 cycles after accept; holds 80 cycles; ramps to 0 in 32 cycles; done high for 1 cycle.
- Clamp/saturation: target 2000 -> ramp stops at 1400. Target 1150 -> steps ...1000,1100,1150 then HOLD. Ramp down goes 1050,...,50,0, never wrapping.
- Unbalance: pulse unbalance at motor_rpm 600 -> REDIST, retry_count 1, ramps to 0, re-ramps to 800. A fourth unbalance -> ramps to 0 -> FAULT; fault_ack -> IDLE.
- Door open at motor_rpm 500 in HOLD -> next edge motor_rpm=0, fault=1, busy=0. start is ignored until fault_ack.
- Abort during RAMP_UP at 300 -> ramps down 200,100,0 -> IDLE, no done pulse. Abort asserted together with unbalance -> abort wins and retry_count is unchanged.
- Async reset mid-HOLD at 800 -> all outputs 0 immediately, without waiting for a clk edge. With SPIN_CYCLE_DERATE_EN defined, target 800 with two unbalances -> re-ramp targets 600, then 400.
